// File: rtl/pc_gen_pkg.sv
// Shared pc_gen definitions: next-PC mode encodings, FSM states, default vectors.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_gen_pkg;

    localparam logic [2:0] SEL_SEQ  = 3'd0;
    localparam logic [2:0] SEL_BR   = 3'd1;
    localparam logic [2:0] SEL_J    = 3'd2;
    localparam logic [2:0] SEL_JR   = 3'd3;
    localparam logic [2:0] SEL_JAL  = 3'd4;
    localparam logic [2:0] SEL_RET  = 3'd5;
    localparam logic [2:0] SEL_ERET = 3'd6;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_EXC    = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Controller <-> pc_gen bundle: next-PC controls in, PC/exception status out.
// Latency: n/a (wiring only).
// Backpressure: stall freezes the consumer; no other flow control.
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic [2:0]      pc_sel;
    logic            br_taken;
    logic [25:0]     imm;
    logic [XLEN-1:0] grf_a;
    logic            exc_req;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] epc;
    logic            in_exc;
    logic            ras_hit;

    modport master (
        output stall, pc_sel, br_taken, imm, grf_a, exc_req,
        input  pc, next_pc, epc, in_exc, ras_hit
    );

    modport slave (
        input  stall, pc_sel, br_taken, imm, grf_a, exc_req,
        output pc, next_pc, epc, in_exc, ras_hit
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push on a full stack overwrites the oldest entry.
// Latency: push/pop take effect at the clock edge; top/empty/full reflect registered state.
// Backpressure: none; pop on an empty stack is ignored.
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [XLEN-1:0] push_dat,
    input  logic            pop,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W-1:0] push_ptr;
    logic [CNT_W-1:0] count;

    // Pointer wraps naturally because RAS_DEPTH is a power of two.
    assign push_ptr = top_ptr + 1'b1;
    assign top      = mem[top_ptr];
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(RAS_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (push) begin
            top_ptr <= push_ptr;
            count   <= full ? count : count + 1'b1;
        end else if (pop && !empty) begin
            top_ptr <= top_ptr - 1'b1;
            count   <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[push_ptr] <= push_dat;
        end
    end
endmodule

// File: rtl/pc_gen.sv
// Program-counter register and next-PC selection (SEQ/BR/J/JR/JAL/RET/ERET, exceptions); RAS under PC_GEN_RAS_EN.
// Latency: next_pc combinational, pc/epc/state registered one edge later.
// Backpressure: stall freezes pc, epc, state and stack; next_pc still computed.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEF_RESET_PC),
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(DEF_EXC_VEC),
    parameter int              RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    pc_gen_if.slave  bus
);
    if ((XLEN < 32) || (RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_cfg
        $error("pc_gen: XLEN must be >= 32 and RAS_DEPTH a power of two >= 2");
    end

    pc_state_e       state, state_n;
    logic [XLEN-1:0] pc_q, epc_q, epc_n, next_pc;
    logic [XLEN-1:0] pc4, br_off, j_target;
    logic            misaligned, exc, ras_hit;

    assign pc4      = pc_q + XLEN'(4);
    assign br_off   = {{(XLEN-18){bus.imm[15]}}, bus.imm[15:0], 2'b00};
    assign j_target = {pc4[XLEN-1:28], bus.imm, 2'b00};

    assign misaligned = ((bus.pc_sel == SEL_JR) || (bus.pc_sel == SEL_RET))
                        && (bus.grf_a[1:0] != 2'b00);
    assign exc        = bus.exc_req || misaligned;

`ifdef PC_GEN_RAS_EN
    logic            ras_push, ras_pop, ras_empty;
    logic [XLEN-1:0] ras_top;

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (ras_push && !bus.stall),
        .push_dat (pc_q + XLEN'(8)),
        .pop      (ras_pop && !bus.stall),
        .top      (ras_top),
        .empty    (ras_empty),
        .full     ()
    );
`endif

    always_comb begin
        next_pc = pc4;
        state_n = state;
        epc_n   = epc_q;
        ras_hit = 1'b0;
`ifdef PC_GEN_RAS_EN
        ras_push = 1'b0;
        ras_pop  = 1'b0;
`endif
        if (exc) begin
            // A nested exception re-vectors but keeps the original return point.
            next_pc = EXC_VEC;
            state_n = ST_EXC;
            if (state == ST_NORMAL) begin
                epc_n = pc_q;
            end
        end else begin
            case (bus.pc_sel)
                SEL_BR: begin
                    if (bus.br_taken) begin
                        next_pc = pc4 + br_off;
                    end
                end
                SEL_J: next_pc = j_target;
                SEL_JAL: begin
                    next_pc = j_target;
`ifdef PC_GEN_RAS_EN
                    ras_push = 1'b1;
`endif
                end
                SEL_JR: next_pc = bus.grf_a;
                SEL_RET: begin
                    next_pc = bus.grf_a;
`ifdef PC_GEN_RAS_EN
                    if (!ras_empty) begin
                        ras_pop = 1'b1;
                        if (ras_top == bus.grf_a) begin
                            next_pc = ras_top;
                            ras_hit = 1'b1;
                        end
                    end
`endif
                end
                SEL_ERET: begin
                    if (state == ST_EXC) begin
                        next_pc = epc_q;
                        state_n = ST_NORMAL;
                    end
                end
                default: next_pc = pc4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            epc_q <= '0;
            state <= ST_NORMAL;
        end else if (!bus.stall) begin
            pc_q  <= next_pc;
            epc_q <= epc_n;
            state <= state_n;
        end
    end

    assign bus.pc      = pc_q;
    assign bus.next_pc = next_pc;
    assign bus.epc     = epc_q;
    assign bus.in_exc  = (state == ST_EXC);
    assign bus.ras_hit = ras_hit;
endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; RAS scenario runs when PC_GEN_RAS_EN is defined.
module tb_pc_gen;
    import pc_gen_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pc_gen_if #(.XLEN(32)) bus ();

    pc_gen #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [2:0] sel, input logic [25:0] im, input logic [31:0] ga,
                         input logic taken, input logic exc, input logic stl);
        bus.pc_sel   = sel;
        bus.imm      = im;
        bus.grf_a    = ga;
        bus.br_taken = taken;
        bus.exc_req  = exc;
        bus.stall    = stl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [31:0] addr);
        drive(SEL_JR, 26'd0, addr, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(SEL_J, 26'h3FF_FFFF, 32'h0, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        checks++; if (bus.pc !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h3000); end
        checks++; if (bus.epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want %h", bus.epc, 32'h0); end
        checks++; if (bus.in_exc !== 1'b0) begin errors++; $display("FAIL reset_in_exc: got %b want 0", bus.in_exc); end
        checks++; if (bus.ras_hit !== 1'b0) begin errors++; $display("FAIL reset_ras_hit: got %b want 0", bus.ras_hit); end
        reset = 1'b0;
        drive(SEL_SEQ, 26'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (bus.pc !== 32'h3004) begin errors++; $display("FAIL seq_1: got %h want %h", bus.pc, 32'h3004); end
        tick();
        checks++; if (bus.pc !== 32'h3008) begin errors++; $display("FAIL seq_2: got %h want %h", bus.pc, 32'h3008); end
        tick();
        checks++; if (bus.pc !== 32'h300C) begin errors++; $display("FAIL seq_3: got %h want %h", bus.pc, 32'h300C); end
    endtask

    task automatic test_branch();
        go_to(32'h3010);
        checks++; if (bus.pc !== 32'h3010) begin errors++; $display("FAIL jr_setup: got %h want %h", bus.pc, 32'h3010); end
        drive(SEL_BR, 26'h000FFFC, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (bus.next_pc !== 32'h3004) begin errors++; $display("FAIL br_back_next: got %h want %h", bus.next_pc, 32'h3004); end
        tick();
        checks++; if (bus.pc !== 32'h3004) begin errors++; $display("FAIL br_back_pc: got %h want %h", bus.pc, 32'h3004); end
        go_to(32'h3010);
        drive(SEL_BR, 26'h000FFFC, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (bus.pc !== 32'h3014) begin errors++; $display("FAIL br_not_taken: got %h want %h", bus.pc, 32'h3014); end
        drive(SEL_BR, 26'h0000004, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (bus.pc !== 32'h3028) begin errors++; $display("FAIL br_fwd: got %h want %h", bus.pc, 32'h3028); end
    endtask

    task automatic test_jump();
        go_to(32'h3000_0000);
        drive(SEL_J, 26'h0000400, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (bus.pc !== 32'h3000_1000) begin errors++; $display("FAIL j_target: got %h want %h", bus.pc, 32'h3000_1000); end
        drive(SEL_JAL, 26'h0000800, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (bus.pc !== 32'h3000_2000) begin errors++; $display("FAIL jal_target: got %h want %h", bus.pc, 32'h3000_2000); end
        drive(3'd7, 26'h0000800, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (bus.pc !== 32'h3000_2004) begin errors++; $display("FAIL sel7_seq: got %h want %h", bus.pc, 32'h3000_2004); end
        go_to(32'hFFFF_FFFC);
        drive(SEL_SEQ, 26'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h want %h", bus.pc, 32'h0); end
    endtask

    task automatic test_stall();
        go_to(32'h3000_0000);
        drive(SEL_J, 26'h0000400, 32'h0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (bus.next_pc !== 32'h3000_1000) begin errors++; $display("FAIL stall_next: got %h want %h", bus.next_pc, 32'h3000_1000); end
        tick();
        checks++; if (bus.pc !== 32'h3000_0000) begin errors++; $display("FAIL stall_pc: got %h want %h", bus.pc, 32'h3000_0000); end
        drive(SEL_SEQ, 26'd0, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        checks++; if (bus.pc !== 32'h3000_0000) begin errors++; $display("FAIL stall_exc_pc: got %h want %h", bus.pc, 32'h3000_0000); end
        checks++; if (bus.in_exc !== 1'b0) begin errors++; $display("FAIL stall_exc_state: got %b want 0", bus.in_exc); end
        checks++; if (bus.epc !== 32'h0) begin errors++; $display("FAIL stall_exc_epc: got %h want %h", bus.epc, 32'h0); end
        drive(SEL_J, 26'h0000400, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (bus.pc !== 32'h3000_1000) begin errors++; $display("FAIL stall_release: got %h want %h", bus.pc, 32'h3000_1000); end
    endtask

    task automatic test_exception();
        go_to(32'h3020);
        drive(SEL_SEQ, 26'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        #1;
        checks++; if (bus.next_pc !== 32'h4180) begin errors++; $display("FAIL exc_next: got %h want %h", bus.next_pc, 32'h4180); end
        tick();
        checks++; if (bus.pc !== 32'h4180) begin errors++; $display("FAIL exc_pc: got %h want %h", bus.pc, 32'h4180); end
        checks++; if (bus.epc !== 32'h3020) begin errors++; $display("FAIL exc_epc: got %h want %h", bus.epc, 32'h3020); end
        checks++; if (bus.in_exc !== 1'b1) begin errors++; $display("FAIL exc_state: got %b want 1", bus.in_exc); end
        drive(SEL_SEQ, 26'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(SEL_SEQ, 26'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (bus.pc !== 32'h4180) begin errors++; $display("FAIL nested_pc: got %h want %h", bus.pc, 32'h4180); end
        checks++; if (bus.epc !== 32'h3020) begin errors++; $display("FAIL nested_epc: got %h want %h", bus.epc, 32'h3020); end
        drive(SEL_ERET, 26'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (bus.pc !== 32'h3020) begin errors++; $display("FAIL eret_pc: got %h want %h", bus.pc, 32'h3020); end
        checks++; if (bus.in_exc !== 1'b0) begin errors++; $display("FAIL eret_state: got %b want 0", bus.in_exc); end
        tick();
        checks++; if (bus.pc !== 32'h3024) begin errors++; $display("FAIL eret_normal_seq: got %h want %h", bus.pc, 32'h3024); end
        drive(SEL_JR, 26'd0, 32'h3002, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (bus.pc !== 32'h4180) begin errors++; $display("FAIL misalign_pc: got %h want %h", bus.pc, 32'h4180); end
        checks++; if (bus.epc !== 32'h3024) begin errors++; $display("FAIL misalign_epc: got %h want %h", bus.epc, 32'h3024); end
        checks++; if (bus.in_exc !== 1'b1) begin errors++; $display("FAIL misalign_state: got %b want 1", bus.in_exc); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        drive(SEL_J, 26'h0000400, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        reset = 1'b0;
        checks++; if (bus.pc !== 32'h3000) begin errors++; $display("FAIL mid_reset_pc: got %h want %h", bus.pc, 32'h3000); end
        checks++; if (bus.epc !== 32'h0) begin errors++; $display("FAIL mid_reset_epc: got %h want %h", bus.epc, 32'h0); end
        checks++; if (bus.in_exc !== 1'b0) begin errors++; $display("FAIL mid_reset_state: got %b want 0", bus.in_exc); end
    endtask

`ifdef PC_GEN_RAS_EN
    task automatic test_ras();
        logic [25:0] jal_imm [5];
        logic [31:0] link [5];
        jal_imm = '{26'h0000C40, 26'h0000C80, 26'h0000CC0, 26'h0000D00, 26'h0000D40};
        link    = '{32'h3008, 32'h3108, 32'h3208, 32'h3308, 32'h3408};
        go_to(32'h3000);
        drive(SEL_JAL, 26'h0000C00, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (bus.pc !== 32'h3000) begin errors++; $display("FAIL ras_jal_pc: got %h want %h", bus.pc, 32'h3000); end
        drive(SEL_RET, 26'd0, 32'h3008, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.ras_hit !== 1'b1) begin errors++; $display("FAIL ras_hit: got %b want 1", bus.ras_hit); end
        tick();
        checks++; if (bus.pc !== 32'h3008) begin errors++; $display("FAIL ras_ret_pc: got %h want %h", bus.pc, 32'h3008); end
        #1;
        checks++; if (bus.ras_hit !== 1'b0) begin errors++; $display("FAIL ras_empty_hit: got %b want 0", bus.ras_hit); end
        go_to(32'h3000);
        for (int i = 0; i < 5; i++) begin
            drive(SEL_JAL, jal_imm[i], 32'h0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        checks++; if (bus.pc !== 32'h3500) begin errors++; $display("FAIL ras_chain_pc: got %h want %h", bus.pc, 32'h3500); end
        for (int i = 4; i >= 0; i--) begin
            drive(SEL_RET, 26'd0, link[i], 1'b0, 1'b0, 1'b0);
            #1;
            checks++;
            if (bus.ras_hit !== (i != 0)) begin
                errors++;
                $display("FAIL ras_depth_hit[%0d]: got %b want %b", i, bus.ras_hit, (i != 0));
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_stall();
        test_exception();
        test_reset_mid();
`ifdef PC_GEN_RAS_EN
        test_ras();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the MIPS core: holds the architectural PC register and computes the next PC for sequential, branch, jump, register-jump, exception and exception-return flows. It sits at the front of the datapath, drives the instruction-memory address, and absorbs stall and exception control from the controller. An optional return-address stack accelerates function returns.

## Interface
- XLEN, 32: PC/data width; must be ≥ 32.
- RESET_PC, 32'h0000_3000: PC loaded on reset.
- EXC_VEC, 32'h0000_4180: exception entry vector.
- RAS_DEPTH, 4: return-address-stack entries (power of two, ≥ 2); used only with PC_GEN_RAS_EN.
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and all internal state this cycle.
- pc_sel  input  3  next-PC mode (encodings in Operation).
- br_taken  input  1  branch condition (ALU zero) for BR mode.
- imm  input  26  instruction immediate field ([15:0] for BR, [25:0] for J/JAL).
- grf_a  input  XLEN  rs register value for JR/RET.
- exc_req  input  1  exception request from the current instruction.
- pc  output  XLEN  current PC (register).
- next_pc  output  XLEN  combinational next PC.
- epc  output  XLEN  saved exception PC.
- in_exc  output  1  high while in exception handler state.
- ras_hit  output  1  RET used the stack top (always 0 without PC_GEN_RAS_EN).

## Operation
- pc_sel encodings: 0 SEQ, 1 BR, 2 J, 3 JR, 4 JAL, 5 RET, 6 ERET, 7 reserved (treated as SEQ).
- pc4 = pc + 4, modulo 2^XLEN.
- SEQ: pc4. BR: br_taken ? pc4 + (sext(imm[15:0]) << 2) : pc4. J/JAL: {pc4[XLEN-1:28], imm[25:0], 2'b00}. JR: grf_a. RET: as JR unless a stack hit occurs (Configuration).
- JAL pushes pc + 8 (the link address) when PC_GEN_RAS_EN is defined.
- Misaligned target (JR/RET with grf_a[1:0] ≠ 0): treated as an exception; epc = pc.
- Priority each cycle: reset > stall > exception (exc_req or misaligned) > pc_sel.
- State machine, 2 states:
  - NORMAL: exception → next_pc = EXC_VEC, epc ← pc, go to EXC. ERET in NORMAL behaves as SEQ.
  - EXC: ERET → next_pc = epc, go to NORMAL. A nested exception → next_pc = EXC_VEC, epc unchanged, stay in EXC.
- in_exc = (state == EXC).
- Stall: pc, epc, state and stack are all frozen. next_pc still reflects the computed value.
- Reset values: pc = RESET_PC, epc = 0, state NORMAL, in_exc = 0, stack empty, ras_hit = 0.

## Timing
- pc updates at the posedge following next_pc; redirect latency is 1 cycle, with no bubble generated internally.
- next_pc and ras_hit are purely combinational from current state and inputs.
- epc and state update in the same edge as pc.
- Reset asserted mid-flow overrides stall and exceptions on that edge.
- JAL push and RET pop take effect at the edge; the stack top is visible to the next cycle's RET.

## Configuration
- PC_GEN_RAS_EN defined: instantiate a RAS_DEPTH circular stack.
  - JAL pushes; on a full stack, the oldest entry is overwritten.
  - RET with a non-empty stack pops. If top == grf_a, next_pc = top and ras_hit = 1. On mismatch, next_pc = grf_a and the pop still occurs.
  - RET on an empty stack uses grf_a with ras_hit = 0.
  - Exception entry does not touch the stack.
- PC_GEN_RAS_EN undefined: no stack storage; RET ≡ JR; ras_hit tied 0.

## Structure
- Shared package pc_gen_pkg: pc_sel encoding constants, state encoding, default RESET_PC and EXC_VEC.
- One sub-module, pc_ras: push, pop, top, empty, full; parametrised by XLEN and RAS_DEPTH; instantiated only under PC_GEN_RAS_EN.

## Test plan
- Reset: hold reset for 2 cycles → pc = 0x3000, epc = 0, in_exc = 0. Release with SEQ for 3 cycles → pc = 0x3004, 0x3008, 0x300C.
- Branch: pc = 0x3010, BR with imm = 0xFFFC, br_taken = 1 → next pc 0x3004. With br_taken = 0 → next pc 0x3014.
- J: pc = 0x3000_0000, J with imm = 0x0000_400 → next pc 0x3000_1000.
- Stall: stall = 1 during J → pc unchanged and epc/state unchanged. Deassert → jump taken next edge.
- Exception: pc = 0x3020 with exc_req → pc = 0x4180, epc = 0x3020, in_exc = 1. A nested exc_req leaves epc = 0x3020. ERET → pc = 0x3020, in_exc = 0. JR with grf_a = 0x3002 → exception, epc = pc.
- RAS (PC_GEN_RAS_EN): JAL at 0x3000 → push 0x3008. RET with grf_a = 0x3008 → ras_hit = 1, pc = 0x3008. Five JALs with depth 4 → oldest entry lost. RET on an empty stack → ras_hit = 0.
